// File: rtl/shared_timer_arbiter.sv
// Two-requester arbiter sharing one down-counter: a granted requester owns the
// counter from its load value down to zero, then gets a one-cycle done pulse.
module shared_timer_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] load0,
  input  logic [WIDTH-1:0] load1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic [1:0]       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             ptr, ptr_next;
  logic             owner, owner_next;
  logic [1:0]       gnt_next;
  logic [1:0]       done_next;
  logic [WIDTH-1:0] count_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      owner <= 1'b0;
      gnt   <= '0;
      done  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
      gnt   <= gnt_next;
      done  <= done_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    gnt_next   = gnt;
    done_next  = '0;
    count_next = count;
    case (state)
      IDLE: begin
        gnt_next   = '0;
        count_next = '0;
        if (req != 2'b00) begin
          // Contention is settled only by ptr; a lone request wins outright.
          owner_next = (req == 2'b11) ? ptr : req[1];
          gnt_next   = owner_next ? 2'b10 : 2'b01;
          count_next = owner_next ? load1 : load0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!req[owner]) begin
          state_next = IDLE;
          gnt_next   = '0;
          count_next = '0;
          ptr_next   = ~owner;
        end else if (count == '0) begin
          state_next = DONE;
          done_next  = gnt;
        end else begin
          count_next = count - WIDTH'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        gnt_next   = '0;
        count_next = '0;
        ptr_next   = ~owner;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        count_next = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Bench for shared_timer_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a grant-age model of the arbiter.
module tb_shared_timer_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  logic [WIDTH-1:0] load0;
  logic [WIDTH-1:0] load1;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic [1:0]       done;

  int tests;
  int fails;

  shared_timer_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .load0 (load0),
    .load1 (load1),
    .gnt   (gnt),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: who owns the counter (-1 = nobody), its sampled load, and how many
  // edges have passed since the grant. Ages 0..load are counting, load+1 is done.
  int m_owner = -1;
  int m_load  = 0;
  int m_age   = 0;
  int m_ptr   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_age   = 0;
      m_load  = 0;
    end else if (m_owner < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) m_owner = m_ptr;
        else              m_owner = req[1] ? 1 : 0;
        m_load = (m_owner == 1) ? int'(load1) : int'(load0);
        m_age  = 0;
      end
    end else if (m_age > m_load) begin
      m_ptr   = 1 - m_owner;
      m_owner = -1;
    end else if (!req[m_owner]) begin
      m_ptr   = 1 - m_owner;
      m_owner = -1;
    end else begin
      m_age = m_age + 1;
    end
  end

  function automatic int exp_gnt();
    return (m_owner < 0) ? 0 : (1 << m_owner);
  endfunction

  function automatic int exp_count();
    return (m_owner >= 0 && m_age <= m_load) ? (m_load - m_age) : 0;
  endfunction

  function automatic int exp_done();
    return (m_owner >= 0 && m_age == m_load + 1) ? (1 << m_owner) : 0;
  endfunction

  function automatic int exp_busy();
    return (m_owner >= 0) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_gnt",   int'(gnt),   exp_gnt());
    check("model_count", int'(count), exp_count());
    check("model_done",  int'(done),  exp_done());
    check("model_busy",  int'(busy),  exp_busy());
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 2'b00;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    req   = 2'b00;
    load0 = '0;
    load1 = '0;
    #1 rst = 1'b1;
    nclk(2);
    check("reset_gnt",   int'(gnt),   0);
    check("reset_count", int'(count), 0);
    check("reset_busy",  int'(busy),  0);
    check("reset_done",  int'(done),  0);
    #1 rst = 1'b0;

    // Single request, load 3
    req = 2'b01; load0 = 4'd3;
    nclk(1); check("single_gnt", int'(gnt), 1); check("single_c3", int'(count), 3);
    nclk(1); check("single_c2", int'(count), 2);
    nclk(1); check("single_c1", int'(count), 1);
    nclk(1); check("single_c0", int'(count), 0); check("single_nodone", int'(done), 0);
    nclk(1); check("single_done", int'(done), 1); check("single_done_gnt", int'(gnt), 1);
    req = 2'b00;
    nclk(1); check("single_idle_gnt", int'(gnt), 0); check("single_idle_busy", int'(busy), 0);

    // Tie after reset, then alternation
    do_reset();
    req = 2'b11; load0 = 4'd1; load1 = 4'd2;
    nclk(1); check("tie_gnt0", int'(gnt), 1); check("tie_c1", int'(count), 1);
    nclk(1); check("tie_c0", int'(count), 0);
    nclk(1); check("tie_done0", int'(done), 1);
    nclk(1); check("tie_gap", int'(gnt), 0);
    nclk(1); check("tie_gnt1", int'(gnt), 2); check("tie_c2", int'(count), 2);
    nclk(1); check("tie_b_c1", int'(count), 1);
    nclk(1); check("tie_b_c0", int'(count), 0);
    nclk(1); check("tie_done1", int'(done), 2);
    req = 2'b00;
    nclk(1);

    // Zero load
    req = 2'b10; load1 = 4'd0;
    nclk(1); check("zero_gnt", int'(gnt), 2); check("zero_count", int'(count), 0);
    check("zero_nodone", int'(done), 0);
    nclk(1); check("zero_done", int'(done), 2);
    req = 2'b00;
    nclk(1); check("zero_idle", int'(gnt), 0);

    // Abort while count=5, then ptr must favour requester 1
    req = 2'b01; load0 = 4'd9;
    nclk(1); check("abort_c9", int'(count), 9);
    nclk(4); check("abort_c5", int'(count), 5);
    req = 2'b00;
    nclk(1); check("abort_gnt", int'(gnt), 0); check("abort_count", int'(count), 0);
    check("abort_done", int'(done), 0);
    req = 2'b11;
    nclk(1); check("abort_ptr", int'(gnt), 2);
    req = 2'b00;
    nclk(1);

    // Asynchronous reset mid-countdown
    req = 2'b01; load0 = 4'd9;
    nclk(1); check("areset_c9", int'(count), 9);
    nclk(3); check("areset_c6", int'(count), 6);
    #1 rst = 1'b1;
    #1;
    check("areset_gnt", int'(gnt), 0); check("areset_count", int'(count), 0);
    check("areset_busy", int'(busy), 0); check("areset_done", int'(done), 0);
    req = 2'b11;
    #1 rst = 1'b0;
    nclk(1); check("areset_regrant", int'(gnt), 1);
    req = 2'b00;
    nclk(1);

    // Load changed after grant must not matter
    do_reset();
    req = 2'b01; load0 = 4'd4;
    nclk(1); check("stable_c4", int'(count), 4);
    load0 = 4'd15;
    nclk(1); check("stable_c3", int'(count), 3);
    nclk(3); check("stable_c0", int'(count), 0);
    nclk(1); check("stable_done", int'(done), 1);
    req = 2'b00;
    nclk(1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      load0 = WIDTH'($urandom);
      load1 = WIDTH'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    nclk(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
